// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the video RAM CPU bridge
package vga_pkg;

    localparam int         VGA_ADDR_W   = 14;
    localparam logic [7:0] VGA_OOW_DATA = 8'hFF;

    typedef struct packed {
        logic                  we;
        logic [VGA_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } vga_req_t;

    localparam int VGA_REQ_W = $bits(vga_req_t);

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_DRAIN,
        RD_ISSUE,
        RD_WAITRSP,
        RD_HOLD
    } vga_rd_state_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// rtl/vga_wr_fifo.sv - posted-write FIFO of video RAM requests
module vga_wr_fifo
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK_25,
    input  logic                        nRST,
    input  logic                        push,
    input  logic                        pop,
    input  logic [VGA_REQ_W-1:0]        wdata,
    output logic [VGA_REQ_W-1:0]        rdata,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [VGA_REQ_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic                 do_push;
    logic                 do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK_25) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge CLK_25 or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr_q];

endmodule

// File: rtl/vga_cpu_bridge.sv
// rtl/vga_cpu_bridge.sv - Z80 bus to video RAM slot bridge with posted writes
// Read path and read FSM are built only when VGA_BRIDGE_RD_EN is defined.
module vga_cpu_bridge
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = VGA_ADDR_W
) (
    input  logic              CLK_25,
    input  logic              nRST,
    input  logic [14:0]       CPU_A,
    input  logic [7:0]        CPU_D_IN,
    output logic [7:0]        CPU_D_OUT,
    output logic              CPU_D_OE,
    input  logic              CPU_nCS,
    input  logic              CPU_nWR,
    input  logic              CPU_nRD,
    output logic              CPU_nWAIT,
    output logic              REQ_VALID,
    input  logic              REQ_READY,
    output logic              REQ_WE,
    output logic [ADDR_W-1:0] REQ_ADDR,
    output logic [7:0]        REQ_DATA,
    input  logic              RSP_VALID,
    input  logic [7:0]        RSP_DATA,
    output logic              OVF
);

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       wr_prev_q;
    logic       rd_prev_q;
    logic       cs_n_s;
    logic       wr_n_s;
    logic       rd_n_s;
    logic       wr_start;
    logic       in_window;

    // Strobes are {nCS, nWR, nRD}; idle high so reset never looks like an edge.
    always_ff @(posedge CLK_25 or negedge nRST) begin
        if (!nRST) begin
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            wr_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
        end else begin
            sync1_q   <= {CPU_nCS, CPU_nWR, CPU_nRD};
            sync2_q   <= sync1_q;
            wr_prev_q <= sync2_q[1];
            rd_prev_q <= sync2_q[0];
        end
    end

    assign cs_n_s    = sync2_q[2];
    assign wr_n_s    = sync2_q[1];
    assign rd_n_s    = sync2_q[0];
    assign wr_start  = wr_prev_q && !wr_n_s && !cs_n_s;
    assign in_window = !CPU_A[14];

    vga_req_t                   cap_q, skid_q, out_q, fifo_head;
    logic                       cap_v, skid_v, out_v;
    logic [VGA_REQ_W-1:0]       fifo_rdata;
    logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       skid_load, wr_stall;
    logic                       rd_load;
    logic [ADDR_W-1:0]          rd_addr_q;

    assign fifo_head = vga_req_t'(fifo_rdata);
    assign fifo_pop  = !fifo_empty && (!out_v || REQ_READY);
    assign fifo_push = skid_v && (!fifo_full || fifo_pop);
    assign wr_stall  = skid_v && !fifo_push;
    assign skid_load = cap_v && (!skid_v || fifo_push);

    vga_wr_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_wr_fifo (
        .CLK_25(CLK_25),
        .nRST  (nRST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (skid_q),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Capture -> skid -> FIFO -> registered request slot shared with the read FSM.
    always_ff @(posedge CLK_25 or negedge nRST) begin
        if (!nRST) begin
            cap_v  <= 1'b0;
            skid_v <= 1'b0;
            out_v  <= 1'b0;
            cap_q  <= '0;
            skid_q <= '0;
            out_q  <= '0;
            OVF    <= 1'b0;
        end else begin
            if (wr_start && in_window) begin
                cap_v <= 1'b1;
                cap_q <= '{we: 1'b1, addr: VGA_ADDR_W'(CPU_A[ADDR_W-1:0]), data: CPU_D_IN};
            end else if (skid_load) begin
                cap_v <= 1'b0;
            end
            if (skid_load) begin
                skid_v <= 1'b1;
                skid_q <= cap_q;
            end else if (fifo_push) begin
                skid_v <= 1'b0;
            end
            if (fifo_pop) begin
                out_v <= 1'b1;
                out_q <= fifo_head;
            end else if (rd_load) begin
                out_v <= 1'b1;
                out_q <= '{we: 1'b0, addr: VGA_ADDR_W'(rd_addr_q), data: 8'h00};
            end else if (REQ_READY) begin
                out_v <= 1'b0;
            end
            if (wr_stall) begin
                OVF <= 1'b1;
            end
        end
    end

    assign REQ_VALID = out_v;
    assign REQ_ADDR  = out_q.addr[ADDR_W-1:0];
    assign REQ_DATA  = out_q.data;

    logic unused_cnt;
    assign unused_cnt = ^fifo_count;

`ifdef VGA_BRIDGE_RD_EN
    vga_rd_state_t state_q, state_n;
    logic [7:0]    dout_q, dout_n;
    logic          oe_q, oe_n, rd_wait_q, rd_wait_n;
    logic          rd_start, drained;

    // A write start wins over a simultaneous read start.
    assign rd_start = rd_prev_q && !rd_n_s && !cs_n_s && !wr_start;
    assign drained  = fifo_empty && !cap_v && !skid_v && !out_v;

    always_ff @(posedge CLK_25 or negedge nRST) begin
        if (!nRST) begin
            state_q   <= RD_IDLE;
            dout_q    <= '0;
            oe_q      <= 1'b0;
            rd_wait_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_n;
            dout_q    <= dout_n;
            oe_q      <= oe_n;
            rd_wait_q <= rd_wait_n;
            if (rd_start && state_q == RD_IDLE) begin
                rd_addr_q <= CPU_A[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        state_n   = state_q;
        dout_n    = dout_q;
        oe_n      = oe_q;
        rd_wait_n = rd_wait_q;
        rd_load   = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (rd_start && in_window) begin
                    state_n   = RD_DRAIN;
                    rd_wait_n = 1'b1;
                end else if (rd_start) begin
                    state_n = RD_HOLD;
                    dout_n  = VGA_OOW_DATA;
                    oe_n    = 1'b1;
                end
            end
            RD_DRAIN: begin
                if (drained) begin
                    state_n = RD_ISSUE;
                    rd_load = 1'b1;
                end
            end
            RD_ISSUE: begin
                if (REQ_READY) begin
                    state_n = RD_WAITRSP;
                end
            end
            RD_WAITRSP: begin
                if (RSP_VALID) begin
                    state_n   = RD_HOLD;
                    dout_n    = RSP_DATA;
                    oe_n      = 1'b1;
                    rd_wait_n = 1'b0;
                end
            end
            RD_HOLD: begin
                if (rd_n_s || cs_n_s) begin
                    state_n = RD_IDLE;
                    oe_n    = 1'b0;
                end
            end
            default: state_n = RD_IDLE;
        endcase
    end

    assign CPU_D_OUT = dout_q;
    assign CPU_D_OE  = oe_q;
    assign REQ_WE    = out_q.we;
    assign CPU_nWAIT = !(rd_wait_q || wr_stall);
`else
    logic unused_rd;
    assign unused_rd = ^{rd_prev_q, rd_n_s, RSP_VALID, RSP_DATA, out_q.we};

    assign rd_load   = 1'b0;
    assign rd_addr_q = '0;
    assign CPU_D_OUT = 8'h00;
    assign CPU_D_OE  = 1'b0;
    assign REQ_WE    = 1'b1;
    assign CPU_nWAIT = !wr_stall;
`endif

endmodule

// File: tb/tb_vga_cpu_bridge.sv
// tb/tb_vga_cpu_bridge.sv - directed self-checking bench for vga_cpu_bridge
module tb_vga_cpu_bridge;

    logic        CLK_25    = 1'b0;
    logic        nRST      = 1'b0;
    logic [14:0] CPU_A     = '0;
    logic [7:0]  CPU_D_IN  = '0;
    logic [7:0]  CPU_D_OUT;
    logic        CPU_D_OE;
    logic        CPU_nCS   = 1'b1;
    logic        CPU_nWR   = 1'b1;
    logic        CPU_nRD   = 1'b1;
    logic        CPU_nWAIT;
    logic        REQ_VALID;
    logic        REQ_READY = 1'b0;
    logic        REQ_WE;
    logic [13:0] REQ_ADDR;
    logic [7:0]  REQ_DATA;
    logic        RSP_VALID = 1'b0;
    logic [7:0]  RSP_DATA  = '0;
    logic        OVF;

    always #20 CLK_25 = ~CLK_25;

    vga_cpu_bridge #(
        .FIFO_DEPTH(4),
        .ADDR_W    (14)
    ) dut (
        .CLK_25   (CLK_25),
        .nRST     (nRST),
        .CPU_A    (CPU_A),
        .CPU_D_IN (CPU_D_IN),
        .CPU_D_OUT(CPU_D_OUT),
        .CPU_D_OE (CPU_D_OE),
        .CPU_nCS  (CPU_nCS),
        .CPU_nWR  (CPU_nWR),
        .CPU_nRD  (CPU_nRD),
        .CPU_nWAIT(CPU_nWAIT),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WE   (REQ_WE),
        .REQ_ADDR (REQ_ADDR),
        .REQ_DATA (REQ_DATA),
        .RSP_VALID(RSP_VALID),
        .RSP_DATA (RSP_DATA),
        .OVF      (OVF)
    );

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t       log_q[$];
    logic [7:0] vram [16384];
    int         n_checks    = 0;
    int         n_errors    = 0;
    int         wait_cycles = 0;
    int         oe_cycles   = 0;
    int         req_cycles  = 0;
    int         rsp_cnt     = 0;
    int         rsp_delay   = 2;
    logic [13:0] rsp_addr   = '0;

    // RAM slot model: logs accepted requests and answers reads after rsp_delay cycles.
    always @(negedge CLK_25) begin
        RSP_VALID = 1'b0;
        if (!CPU_nWAIT) wait_cycles++;
        if (CPU_D_OE) oe_cycles++;
        if (REQ_VALID) req_cycles++;
        if (!nRST) begin
            rsp_cnt = 0;
        end else begin
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    RSP_VALID = 1'b1;
                    RSP_DATA  = vram[rsp_addr];
                end
            end
            if (REQ_VALID && REQ_READY) begin
                log_q.push_back('{we: REQ_WE, addr: REQ_ADDR, data: REQ_DATA});
                if (REQ_WE) begin
                    vram[REQ_ADDR] = REQ_DATA;
                end else begin
                    rsp_addr = REQ_ADDR;
                    rsp_cnt  = rsp_delay;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK_25);
            #5;
        end
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, output logic waited);
        int w0;
        w0       = wait_cycles;
        CPU_A    = a;
        CPU_D_IN = d;
        CPU_nCS  = 1'b0;
        CPU_nWR  = 1'b0;
        step(6);
        CPU_nWR  = 1'b1;
        CPU_nCS  = 1'b1;
        step(3);
        waited = (wait_cycles != w0);
    endtask

    task automatic wait_oe(input string tag);
        int k;
        k = 0;
        while (!CPU_D_OE && k < 40) begin
            step(1);
            k++;
        end
        check(tag, CPU_D_OE, 1'b1);
    endtask

    initial begin
        logic waited;
        int   w0, o0, r0;

        step(3);
        check("rst_nwait", CPU_nWAIT, 1'b1);
        check("rst_req_valid", REQ_VALID, 1'b0);
        check("rst_oe", CPU_D_OE, 1'b0);
        check("rst_dout", CPU_D_OUT, 8'h00);
        check("rst_ovf", OVF, 1'b0);
        check("rst_addr", REQ_ADDR, 14'h0000);
        nRST = 1'b1;
        step(2);

        // single write: REQ_VALID appears on the 6th edge after nWR falls
        REQ_READY = 1'b1;
        w0        = wait_cycles;
        CPU_A     = 15'h0123;
        CPU_D_IN  = 8'h41;
        CPU_nCS   = 1'b0;
        CPU_nWR   = 1'b0;
        step(5);
        check("wr1_lat5", REQ_VALID, 1'b0);
        step(1);
        check("wr1_valid", REQ_VALID, 1'b1);
        check("wr1_we", REQ_WE, 1'b1);
        check("wr1_addr", REQ_ADDR, 14'h0123);
        check("wr1_data", REQ_DATA, 8'h41);
        step(1);
        check("wr1_popped", REQ_VALID, 1'b0);
        CPU_nWR = 1'b1;
        CPU_nCS = 1'b1;
        step(3);
        check("wr1_count", log_q.size(), 1);
        check("wr1_nwait", wait_cycles - w0, 0);

        // out-of-window write is dropped
        log_q.delete();
        cpu_write(15'h4010, 8'h99, waited);
        step(6);
        check("oow_wr_drop", log_q.size(), 0);

        // six writes into a stalled arbiter overflow on the sixth
        REQ_READY = 1'b0;
        log_q.delete();
        for (int i = 0; i < 6; i++) begin
            cpu_write(15'h0200 + 15'(i), 8'hA0 + 8'(i), waited);
            if (i == 4) begin
                check("ovf_w5_ovf", OVF, 1'b0);
                check("ovf_w5_wait", waited, 1'b0);
            end
            if (i == 5) begin
                check("ovf_w6_wait", waited, 1'b1);
            end
        end
        check("ovf_set", OVF, 1'b1);
        check("ovf_head_held", REQ_ADDR, 14'h0200);
        REQ_READY = 1'b1;
        step(14);
        check("ovf_drain_n", log_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            logic [21:0] exp_ad;
            exp_ad = {14'h0200 + 14'(i), 8'hA0 + 8'(i)};
            if (i < log_q.size()) begin
                check($sformatf("ovf_drain_%0d", i), {log_q[i].addr, log_q[i].data}, exp_ad);
            end
        end
        check("ovf_sticky", OVF, 1'b1);
        check("ovf_nwait_rel", CPU_nWAIT, 1'b1);

        // reset with posted writes pending discards them
        REQ_READY = 1'b0;
        cpu_write(15'h0300, 8'h11, waited);
        cpu_write(15'h0301, 8'h22, waited);
        check("rstw_pending", REQ_VALID, 1'b1);
        #5;
        nRST = 1'b0;
        #1;
        check("rstw_valid", REQ_VALID, 1'b0);
        check("rstw_ovf", OVF, 1'b0);
        check("rstw_nwait", CPU_nWAIT, 1'b1);
        step(2);
        nRST = 1'b1;
        REQ_READY = 1'b1;
        log_q.delete();
        step(10);
        check("rstw_lost", log_q.size(), 0);

`ifdef VGA_BRIDGE_RD_EN
        // read-after-write: read waits for the posted write to leave
        REQ_READY = 1'b0;
        log_q.delete();
        cpu_write(15'h1000, 8'h55, waited);
        CPU_A   = 15'h1000;
        CPU_nCS = 1'b0;
        CPU_nRD = 1'b0;
        step(3);
        check("raw_nwait", CPU_nWAIT, 1'b0);
        check("raw_wr_first", {REQ_VALID, REQ_WE}, 2'b11);
        step(2);
        check("raw_drain_hold", CPU_nWAIT, 1'b0);
        REQ_READY = 1'b1;
        wait_oe("raw_oe");
        check("raw_dout", CPU_D_OUT, 8'h55);
        check("raw_nwait_rel", CPU_nWAIT, 1'b1);
        check("raw_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("raw_order0", {log_q[0].we, log_q[0].addr}, {1'b1, 14'h1000});
            check("raw_order1", {log_q[1].we, log_q[1].addr}, {1'b0, 14'h1000});
        end
        CPU_nRD = 1'b1;
        CPU_nCS = 1'b1;
        step(4);
        check("raw_oe_drop", CPU_D_OE, 1'b0);

        // wait latency with empty FIFO
        CPU_nCS = 1'b0;
        CPU_nRD = 1'b0;
        step(2);
        check("rdlat_2", CPU_nWAIT, 1'b1);
        step(1);
        check("rdlat_3", CPU_nWAIT, 1'b0);
        wait_oe("rdlat_oe");
        check("rdlat_dout", CPU_D_OUT, 8'h55);
        CPU_nRD = 1'b1;
        CPU_nCS = 1'b1;
        step(4);

        // out-of-window read answers 0xFF with no request
        log_q.delete();
        w0      = wait_cycles;
        CPU_A   = 15'h4000;
        CPU_nCS = 1'b0;
        CPU_nRD = 1'b0;
        step(3);
        check("oow_rd_oe", CPU_D_OE, 1'b1);
        check("oow_rd_dout", CPU_D_OUT, 8'hFF);
        step(4);
        check("oow_rd_noreq", log_q.size(), 0);
        check("oow_rd_nowait", wait_cycles - w0, 0);
        CPU_nRD = 1'b1;
        CPU_nCS = 1'b1;
        step(4);

        // reset while waiting for the response
        rsp_delay = 30;
        log_q.delete();
        CPU_A   = 15'h1000;
        CPU_nCS = 1'b0;
        CPU_nRD = 1'b0;
        step(8);
        check("rstr_issued", log_q.size(), 1);
        check("rstr_waiting", CPU_nWAIT, 1'b0);
        #5;
        nRST = 1'b0;
        #1;
        check("rstr_nwait", CPU_nWAIT, 1'b1);
        check("rstr_oe", CPU_D_OE, 1'b0);
        check("rstr_valid", REQ_VALID, 1'b0);
        check("rstr_ovf", OVF, 1'b0);
        CPU_nRD = 1'b1;
        CPU_nCS = 1'b1;
        step(3);
        nRST      = 1'b1;
        rsp_delay = 2;
        step(3);
        CPU_A   = 15'h0123;
        CPU_nCS = 1'b0;
        CPU_nRD = 1'b0;
        wait_oe("rstr_after_oe");
        check("rstr_after_dout", CPU_D_OUT, 8'h41);
        CPU_nRD = 1'b1;
        CPU_nCS = 1'b1;
        step(4);
`else
        // reads are ignored without the read path
        log_q.delete();
        w0      = wait_cycles;
        o0      = oe_cycles;
        r0      = req_cycles;
        CPU_A   = 15'h0000;
        CPU_nCS = 1'b0;
        CPU_nRD = 1'b0;
        step(12);
        check("nord_noreq", req_cycles - r0, 0);
        check("nord_nooe", oe_cycles - o0, 0);
        check("nord_nowait", wait_cycles - w0, 0);
        check("nord_log", log_q.size(), 0);
        CPU_nRD = 1'b1;
        CPU_nCS = 1'b1;
        step(4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
